// File: rtl/regfile_readport_pkg.sv
// ----------------------------------------------------------------------------
// regfile_readport_pkg
//   Constants for the register file and the CPU datapath that reads it:
//   the register width, the register index width and the index of the
//   hardwired zero register.
// ----------------------------------------------------------------------------
package regfile_readport_pkg;

  localparam int REG_WIDTH     = 32;
  localparam int REG_ADDR_BITS = 5;

  // Index of the register that always reads as zero.
  localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = 5'd0;

endpackage : regfile_readport_pkg

// File: rtl/regfile_readmux.sv
// ----------------------------------------------------------------------------
// regfile_readmux
//   Combinational read select for one read port of the register file.
//   Priority: the zero register reads 0; a write landing on the addressed
//   register in the same cycle is forwarded (write-first); otherwise the
//   stored word is returned.
//
// Ports
//   regs     in   all DEPTH stored words, entry 0 unused (zero register)
//   rd_addr  in   register index for this port
//   wr_en    in   write strobe of the write port this cycle
//   wr_addr  in   write index this cycle
//   wr_data  in   write data this cycle
//   rd_data  out  selected read value
// ----------------------------------------------------------------------------
module regfile_readmux
  import regfile_readport_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int ADDR_BITS = REG_ADDR_BITS
) (
  input  logic [(1<<ADDR_BITS)-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_BITS-1:0]                 rd_addr,
  input  logic                                 wr_en,
  input  logic [ADDR_BITS-1:0]                 wr_addr,
  input  logic [WIDTH-1:0]                     wr_data,
  output logic [WIDTH-1:0]                     rd_data
);

  always_comb begin
    if (rd_addr == ADDR_BITS'(REG_ZERO)) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      // Same-edge write forwarding: the reader sees the word being written.
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule : regfile_readmux

// File: rtl/regfile_readport.sv
// ----------------------------------------------------------------------------
// regfile_readport
//   32-entry register file, one write port, two synchronous read ports.
//   Register 0 is hardwired to zero. A read requested on edge N presents
//   data and rdvalid after edge N; data registers hold while rden is low.
//
// Ports
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset (clears storage and outputs)
//   wrenable  in   write strobe
//   wraddr    in   write index (writes to index 0 are discarded)
//   wrdata    in   write data
//   rden      in   read request
//   rdaddr1   in   read index, port 1
//   rdaddr2   in   read index, port 2
//   rddata1   out  registered read data, port 1
//   rddata2   out  registered read data, port 2
//   rdvalid   out  one-cycle pulse after each accepted read request
// ----------------------------------------------------------------------------
module regfile_readport
  import regfile_readport_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int ADDR_BITS = REG_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wrenable,
  input  logic [ADDR_BITS-1:0] wraddr,
  input  logic [WIDTH-1:0]     wrdata,
  input  logic                 rden,
  input  logic [ADDR_BITS-1:0] rdaddr1,
  input  logic [ADDR_BITS-1:0] rdaddr2,
  output logic [WIDTH-1:0]     rddata1,
  output logic [WIDTH-1:0]     rddata2,
  output logic                 rdvalid
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Storage for registers 1..DEPTH-1; register 0 has no flops.
  logic [DEPTH-1:1][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0][WIDTH-1:0] regs_view;

  logic [WIDTH-1:0] rddata1_q, rddata1_d;
  logic [WIDTH-1:0] rddata2_q, rddata2_d;
  logic             rdvalid_q, rdvalid_d;

  logic [WIDTH-1:0] mux1_data, mux2_data;
  logic             wr_hit;

  // Full-depth view with the zero register filled in at index 0.
  assign regs_view = {regs_q, {WIDTH{1'b0}}};

  assign wr_hit = wrenable && (wraddr != ADDR_BITS'(REG_ZERO));

  // Write decoder.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps latches from being inferred.
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[wraddr] = wrdata;
    end
  end

  regfile_readmux #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_readmux1 (
    .regs   (regs_view),
    .rd_addr(rdaddr1),
    .wr_en  (wrenable),
    .wr_addr(wraddr),
    .wr_data(wrdata),
    .rd_data(mux1_data)
  );

  regfile_readmux #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_readmux2 (
    .regs   (regs_view),
    .rd_addr(rdaddr2),
    .wr_en  (wrenable),
    .wr_addr(wraddr),
    .wr_data(wrdata),
    .rd_data(mux2_data)
  );

  // Read capture: data registers update only on a request, otherwise hold.
  always_comb begin
    rddata1_d = rddata1_q;
    rddata2_d = rddata2_q;
    rdvalid_d = rden;
    if (rden) begin
      rddata1_d = mux1_data;
      rddata2_d = mux2_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage array is reset on purpose: unwritten registers must
      // read 0 rather than X, and reset must wipe previously written data.
      regs_q    <= '0;
      rddata1_q <= '0;
      rddata2_q <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      regs_q    <= regs_d;
      rddata1_q <= rddata1_d;
      rddata2_q <= rddata2_d;
      rdvalid_q <= rdvalid_d;
    end
  end

  assign rddata1 = rddata1_q;
  assign rddata2 = rddata2_q;
  assign rdvalid = rdvalid_q;

endmodule : regfile_readport

// File: tb/tb_regfile_readport.sv
// ----------------------------------------------------------------------------
// tb_regfile_readport
//   Self-checking bench for regfile_readport: a directed vector table,
//   hand-written reset sequences and a randomized phase checked against an
//   array-based model of the register file.
// ----------------------------------------------------------------------------
module tb_regfile_readport;

  logic        clk;
  logic        reset_n;
  logic        wrenable;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        rden;
  logic [4:0]  rdaddr1;
  logic [4:0]  rdaddr2;
  logic [31:0] rddata1;
  logic [31:0] rddata2;
  logic        rdvalid;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_readport #(
    .WIDTH    (32),
    .ADDR_BITS(5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wrenable(wrenable),
    .wraddr  (wraddr),
    .wrdata  (wrdata),
    .rden    (rden),
    .rdaddr1 (rdaddr1),
    .rdaddr2 (rdaddr2),
    .rddata1 (rddata1),
    .rddata2 (rddata2),
    .rdvalid (rdvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of register contents plus the expected
  // registered outputs.
  logic [31:0] model [32];
  logic [31:0] m_d1, m_d2;
  logic        m_v;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_value(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    m_d1 = 32'd0;
    m_d2 = 32'd0;
    m_v  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit
  // after the rising edge.
  task automatic do_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rd, input logic [4:0] a1, input logic [4:0] a2);
    wrenable = we;
    wraddr   = wa;
    wrdata   = wd;
    rden     = rd;
    rdaddr1  = a1;
    rdaddr2  = a2;
    if (rd) begin
      m_d1 = ref_value(a1, we, wa, wd);
      m_d2 = ref_value(a2, we, wa, wd);
    end
    m_v = rd;
    if (we && wa != 5'd0) model[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e1,
                               input logic [31:0] e2, input logic ev);
    check({tag, ".rddata1"}, rddata1, e1);
    check({tag, ".rddata2"}, rddata2, e2);
    check({tag, ".rdvalid"}, {31'd0, rdvalid}, {31'd0, ev});
  endtask

  initial begin
    logic        r_we, r_rd;
    logic [4:0]  r_wa, r_a1, r_a2;
    logic [31:0] r_wd;

    reset_n  = 1'b0;
    wrenable = 1'b0;
    wraddr   = '0;
    wrdata   = '0;
    rden     = 1'b0;
    rdaddr1  = '0;
    rdaddr2  = '0;
    model_clear();

    // ---- Reset held with the clock running, request lines active ----
    rden     = 1'b1;
    rdaddr1  = 5'd5;
    wrenable = 1'b1;
    wraddr   = 5'd5;
    wrdata   = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("in_reset", 32'd0, 32'd0, 1'b0);
    wrenable = 1'b0;
    rden     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_outputs("after_release", 32'd0, 32'd0, 1'b0);

    // ---- Directed vector table ----
    //            we  wa     wd            rd  a1     a2     e1            e2            ev
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd0,  5'd5,  32'd0,        32'd0,        1'b1});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd31, 5'd0,  32'd0,        32'd0,        1'b1});
    vecs.push_back('{1'b1, 5'd7, 32'd123456789,1'b0, 5'd0,  5'd0,  32'd0,        32'd0,        1'b0});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd7,  5'd0,  32'd123456789,32'd0,        1'b1});
    vecs.push_back('{1'b0, 5'd7, 32'd666666,   1'b0, 5'd7,  5'd7,  32'd123456789,32'd0,        1'b0});
    vecs.push_back('{1'b0, 5'd7, 32'd666666,   1'b0, 5'd7,  5'd7,  32'd123456789,32'd0,        1'b0});
    vecs.push_back('{1'b0, 5'd7, 32'd666666,   1'b0, 5'd7,  5'd7,  32'd123456789,32'd0,        1'b0});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd7,  5'd7,  32'd123456789,32'd123456789,1'b1});
    vecs.push_back('{1'b1, 5'd0, 32'd666666,   1'b0, 5'd0,  5'd0,  32'd123456789,32'd123456789,1'b0});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd0,  5'd0,  32'd0,        32'd0,        1'b1});
    vecs.push_back('{1'b1, 5'd9, 32'd666666,   1'b1, 5'd9,  5'd9,  32'd666666,   32'd666666,   1'b1});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  5'd0,  32'd666666,   32'd666666,   1'b0});
    vecs.push_back('{1'b0, 5'd0, 32'd0,        1'b1, 5'd9,  5'd7,  32'd666666,   32'd123456789,1'b1});
    vecs.push_back('{1'b1, 5'd31,32'hFFFF_FFFF,1'b1, 5'd31, 5'd1,  32'hFFFF_FFFF,32'd0,        1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      do_edge(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].a1, vecs[i].a2);
      check_outputs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ev);
    end

    // ---- Reset mid-read: request accepted, then reset before the next edge ----
    do_edge(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd31);
    check_outputs("pre_midreset", 32'd123456789, 32'hFFFF_FFFF, 1'b1);
    rden    = 1'b1;
    reset_n = 1'b0;
    #1;
    check_outputs("midreset_async", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    do_edge(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    check_outputs("no_replay", 32'd0, 32'd0, 1'b0);
    do_edge(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd9);
    check_outputs("after_midreset", 32'd0, 32'd0, 1'b1);

    // ---- Randomized phase against the model ----
    for (int i = 0; i < 400; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_rd = ($urandom_range(0, 3) != 0);
      // Narrow address range half the time to force bypass and aliasing hits.
      if ($urandom_range(0, 1) == 0) begin
        r_wa = 5'($urandom_range(0, 3));
        r_a1 = 5'($urandom_range(0, 3));
        r_a2 = 5'($urandom_range(0, 3));
      end else begin
        r_wa = 5'($urandom_range(0, 31));
        r_a1 = 5'($urandom_range(0, 31));
        r_a2 = 5'($urandom_range(0, 31));
      end
      r_wd = $urandom;
      do_edge(r_we, r_wa, r_wd, r_rd, r_a1, r_a2);
      check_outputs($sformatf("rand%0d", i), m_d1, m_d2, m_v);
    end

    // ---- Final sweep: read every register back through both ports ----
    for (int a = 0; a < 32; a++) begin
      do_edge(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(31 - a));
      check_outputs($sformatf("sweep%0d", a), m_d1, m_d2, m_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_readport

// File: doc/regfile_readport.md
Name: regfile_readport

Overview:
- Register file built from 32 storage words of WIDTH bits, with one write port and two read ports.
- Register 0 is hardwired to zero.
- The read side is synchronous: a read request is sampled on one clock edge, and the data and valid flag are presented on the next edge.
- It is the read-back counterpart of the enabled 32-bit register and zero register, and feeds operands A/B to the single-cycle and pipelined CPU datapath.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_BITS, 5, address width; depth = 2**ADDR_BITS = 32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wrenable  input  1  write strobe, sampled on the rising clk edge.
- wraddr  input  ADDR_BITS  write register index.
- wrdata  input  WIDTH  write data.
- rden  input  1  read request, sampled on the rising clk edge.
- rdaddr1  input  ADDR_BITS  read port 1 index.
- rdaddr2  input  ADDR_BITS  read port 2 index.
- rddata1  output  WIDTH  registered read data, port 1.
- rddata2  output  WIDTH  registered read data, port 2.
- rdvalid  output  1  high for exactly one cycle following each accepted rden.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset state: while reset_n=0, all 32 registers, rddata1, rddata2 and rdvalid are 0, independent of clk.
- Reset deassertion: the first rising edge with reset_n=1 is a normal edge.
- Write: on a rising edge with wrenable=1 and wraddr!=0, reg[wraddr] <= wrdata.
- Write to register 0: ignored when wraddr=0; reg[0] always reads 0.
- Write hold: with wrenable=0, storage holds; clk activity alone never changes stored data.
- Read latency: the request is sampled at edge N. At edge N, rddataK <= value(rdaddrK), and rdvalid <= 1, so data is visible after edge N. Latency is one cycle.
- Idle: on an edge with rden=0, rdvalid <= 0. rddata1 and rddata2 hold their last value; they are not cleared.
- value(a) is 0 when a=0.
- Write-first bypass: value(a) is wrdata when wrenable=1 and wraddr=a!=0 in the same edge.
- Otherwise value(a) is reg[a].
- Result: a read and write to the same register on the same edge returns the new data.
- Both ports may address the same register; both return identical data.
- Back-to-back reads: rden held high gives rdvalid high every cycle, with new data each cycle.
- Reset mid-operation: reset_n falling clears storage and outputs immediately. An in-flight read is dropped (rdvalid=0) and is not replayed.
- No X propagation: rddata1 and rddata2 are never X after reset, including unwritten registers, which read 0.

Decomposition:
- Shared package/header holds:
  - REG_WIDTH=32, REG_ADDR_BITS=5;
  - REG_ZERO=5'd0 (constant index of the zero register).
- The datapath uses the same header.
- One natural sub-module: regfile_readmux. It is the combinational 32:1 read mux plus zero/bypass select, instantiated once per read port.
- Storage is the existing enabled 32-bit register cells, indexed 1..31, with reg 0 the zero-register cell. The write decoder lives inline.

Test Plan:
- Reset: reset_n=0 with clk toggling, then release; read addresses 0, 5 and 31 -> rddata1/rddata2=0 and rdvalid=1 one cycle after rden.
- Write then read: write 123456789 to r7; next cycle rden with rdaddr1=7, rdaddr2=0 -> rddata1=123456789, rddata2=0 after one edge.
- Hold: wrenable=0, wrdata=666666, wraddr=7, toggle clk 3 times -> read r7 returns 123456789.
- Zero register: wrenable=1, wraddr=0, wrdata=666666 -> read r0 returns 0 on both ports.
- Bypass: same edge with wrenable=1, wraddr=9, wrdata=666666, rden=1, rdaddr1=9, rdaddr2=9 -> both ports 666666. rden=0 on the following edge -> rdvalid=0 and data holds 666666.
- Reset mid-read: rden=1 at edge N, reset_n pulled low before edge N+1 -> rdvalid=0 and rddata=0 immediately. A later read of r7 returns 0.
